sstv_line_sequencer: RTL and testbench
======================================

// Module: sstv_line_sequencer
// PURPOSE
//  Line/frame timing controller sitting between the tone demodulator and sstv_pixel.
//  Hunts for the 1200 Hz line-sync tone and qualifies it by duration, then skips the porch.
//  It then times PIXELS_PER_LINE pixel windows and samples sstv_pixel's 2-bit colour at each window centre.
//  Emits one pixel strobe per window, with x/y coordinates, plus line and frame completion pulses.
// PARAMETERS
//  SYNC_FREQ_LO     1100  lowest freq (Hz) counted as sync tone (inclusive)
//  SYNC_FREQ_HI     1300  highest freq (Hz) counted as sync tone (inclusive)
//  SYNC_MIN_CYCLES  4000  min consecutive sync-tone clocks for a valid sync
//  SYNC_MAX_CYCLES  12000 sync tone held this long = stuck carrier, abort
//  PORCH_CYCLES     1000  clocks skipped after sync before pixel 0
//  PIXEL_CYCLES     457   clocks per pixel window (>=2)
//  PIXELS_PER_LINE  160   pixels per line (1..256)
//  LINES_PER_FRAME  120   lines per frame (1..256)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  enable       in   1   1 = run; 0 = synchronously force IDLE and clear line_y
//  freq         in   12  current demodulated tone frequency, Hz, sampled every clk
//  color        in   2   sstv_pixel output for current freq (combinational)
//  pixel_valid  out  1   one-clk strobe: pixel_color/pixel_x/line_y valid
//  pixel_color  out  2   sampled colour
//  pixel_x      out  8   pixel index within line, 0..PIXELS_PER_LINE-1
//  line_y       out  8   line index within frame, 0..LINES_PER_FRAME-1
//  line_done    out  1   one-clk pulse after last pixel of a line
//  frame_done   out  1   one-clk pulse coincident with line_done of last line
//  sync_err     out  1   one-clk pulse when sync exceeds SYNC_MAX_CYCLES
//  busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, cnt=0; all outputs 0.
//  - in_sync = (freq >= SYNC_FREQ_LO) && (freq <= SYNC_FREQ_HI).
//  - cnt is a 16-bit clock counter; pixel_x and line_y are 8-bit. All are registered.
//  - IDLE: if enable && in_sync -> SYNC, cnt=1.
//  - SYNC, in_sync: cnt++. If cnt reaches SYNC_MAX_CYCLES -> IDLE, pulse sync_err.
//  - SYNC, !in_sync: if cnt >= SYNC_MIN_CYCLES -> PORCH, cnt=0; else -> IDLE (glitch, no pulse).
//  - PORCH: cnt++; on cnt==PORCH_CYCLES-1 -> PIXELS, cnt=0, pixel_x=0. freq is ignored in PORCH.
//  - PIXELS: cnt++ each clk.
//    - Edge where cnt==PIXEL_CYCLES/2 (integer div): registers pixel_color=color and pixel_valid=1 for one clk, with the current pixel_x.
//    - On cnt==PIXEL_CYCLES-1: cnt=0. If pixel_x < PIXELS_PER_LINE-1, pixel_x++.
//      Otherwise -> IDLE and pulse line_done. line_y++, or if line_y==LINES_PER_FRAME-1, line_y=0 and pulse frame_done.
//    - sync tone inside PIXELS is not checked; it is decoded as colour (black).
//  - pixel_x/line_y hold their values between strobes; downstream uses them only when pixel_valid=1.
//  - enable=0 in any state: next clk state=IDLE, cnt=0, line_y=0. A partial line produces no line_done.
//  - Reset mid-line: everything clears immediately; the next frame starts at line_y=0.
//  - Pulses never overlap pixel_valid (strobe at mid-window, line_done at window end).
// TESTING (bench params: SYNC_MIN=4, SYNC_MAX=10, PORCH=2, PIXEL_CYCLES=4, PIXELS_PER_LINE=3, LINES_PER_FRAME=2)
//  1 freq=1200 for 6 clks, then 2200 (color=3) -> 2 porch clks, then 3 pixel_valid strobes 4 clks apart, x=0,1,2, color=3, y=0; line_done 2 clks after last strobe.
//  2 freq=1200 for only 3 clks, then 1500 -> back to IDLE, no pixel_valid, busy low by clk 5.
//  3 freq=1200 held 20 clks -> one sync_err pulse on clk 10, state IDLE; no further pixel_valid or sync_err while tone persists.
//  4 two valid lines back to back -> y=0 then y=1; frame_done with second line_done; third line has y=0.
//  5 enable deasserted at pixel_x=1 -> next clk busy=0, no line_done, line_y=0.
//  6 reset_n low mid-PIXELS, asynchronous to clk -> all outputs 0 immediately.
//    A fresh sync after reset release decodes normally from x=0, y=0.

Source files
------------

// File: rtl/sstv_line_sequencer.sv
// sstv_line_sequencer: qualifies the 1200 Hz line-sync tone, skips the porch, then times
// pixel windows and samples the colour at each window centre.
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                0 forces IDLE and clears line_y
//   freq [11:0], color    demodulated tone (Hz) and its decoded 2-bit colour
//   pixel_valid/color/x   one-clk pixel strobe with colour and x index
//   line_y                line index within frame
//   line_done, frame_done end-of-line / end-of-frame pulses
//   sync_err              sync tone held too long (stuck carrier)
//   busy                  high whenever not IDLE
module sstv_line_sequencer #(
    parameter int SYNC_FREQ_LO    = 1100,
    parameter int SYNC_FREQ_HI    = 1300,
    parameter int SYNC_MIN_CYCLES = 4000,
    parameter int SYNC_MAX_CYCLES = 12000,
    parameter int PORCH_CYCLES    = 1000,
    parameter int PIXEL_CYCLES    = 457,
    parameter int PIXELS_PER_LINE = 160,
    parameter int LINES_PER_FRAME = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [11:0] freq,
    input  logic [1:0]  color,
    output logic        pixel_valid,
    output logic [1:0]  pixel_color,
    output logic [7:0]  pixel_x,
    output logic [7:0]  line_y,
    output logic        line_done,
    output logic        frame_done,
    output logic        sync_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SYNC, PORCH, PIXELS} state_t;
    localparam logic [11:0] F_LO       = 12'(SYNC_FREQ_LO);
    localparam logic [11:0] F_HI       = 12'(SYNC_FREQ_HI);
    localparam logic [15:0] S_MIN      = 16'(SYNC_MIN_CYCLES);
    localparam logic [15:0] S_MAX_PRE  = 16'(SYNC_MAX_CYCLES - 1);
    localparam logic [15:0] PORCH_LAST = 16'(PORCH_CYCLES - 1);
    localparam logic [15:0] MID_PRE    = 16'(PIXEL_CYCLES / 2 - 1);
    localparam logic [15:0] PIX_LAST   = 16'(PIXEL_CYCLES - 1);
    localparam logic [7:0]  X_LAST     = 8'(PIXELS_PER_LINE - 1);
    localparam logic [7:0]  Y_LAST     = 8'(LINES_PER_FRAME - 1);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  col_q, col_d;
    logic        valid_q, valid_d, ldone_q, ldone_d, fdone_q, fdone_d, serr_q, serr_d;
    logic        lock_q, lock_d;
    logic        in_sync;
    assign in_sync = (freq >= F_LO) && (freq <= F_HI);
    // The strobe is registered on the edge where cnt becomes the window centre, so it
    // sits mid-window and line_done (window end) never coincides with it.
    // After a stuck-carrier abort, lock_q keeps IDLE from re-arming until the tone drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        valid_d = 1'b0;
        ldone_d = 1'b0;
        fdone_d = 1'b0;
        serr_d  = 1'b0;
        lock_d  = lock_q & in_sync;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: if (in_sync && !lock_q) begin
                    state_d = SYNC;
                    cnt_d   = 16'd1;
                end
                SYNC: if (in_sync) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == S_MAX_PRE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        serr_d  = 1'b1;
                        lock_d  = 1'b1;
                    end
                end else begin
                    state_d = (cnt_q >= S_MIN) ? PORCH : IDLE;
                    cnt_d   = '0;
                end
                PORCH: if (cnt_q == PORCH_LAST) begin
                    state_d = PIXELS;
                    cnt_d   = '0;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                default: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == MID_PRE) begin
                        valid_d = 1'b1;
                        col_d   = color;
                    end
                    if (cnt_q == PIX_LAST) begin
                        cnt_d = '0;
                        if (x_q < X_LAST) begin
                            x_d = x_q + 8'd1;
                        end else begin
                            state_d = IDLE;
                            ldone_d = 1'b1;
                            fdone_d = (y_q == Y_LAST);
                            y_d     = (y_q == Y_LAST) ? 8'd0 : y_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            ldone_q <= 1'b0;
            fdone_q <= 1'b0;
            serr_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            ldone_q <= ldone_d;
            fdone_q <= fdone_d;
            serr_q  <= serr_d;
            lock_q  <= lock_d;
        end
    end
    assign pixel_valid = valid_q;
    assign pixel_color = col_q;
    assign pixel_x     = x_q;
    assign line_y      = y_q;
    assign line_done   = ldone_q;
    assign frame_done  = fdone_q;
    assign sync_err    = serr_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_sstv_line_sequencer.sv
// tb_sstv_line_sequencer: randomized scenarios checked against an event-timing model.
module tb_sstv_line_sequencer;
    localparam int SMIN = 4, SMAX = 10, PORCH = 2, PC = 4, PPL = 3, LPF = 2;
    logic        clk = 1'b0;
    logic        reset_n, enable;
    logic [11:0] freq;
    logic [1:0]  color;
    logic        pixel_valid, line_done, frame_done, sync_err, busy;
    logic [1:0]  pixel_color;
    logic [7:0]  pixel_x, line_y;
    int edges = 0, errors = 0, checks = 0, exp_y = 0;
    // kind: 0 pixel strobe, 1 line_done, 2 frame_done, 3 sync_err; at = posedge index
    typedef struct {int kind; int at; int x; int y; int col;} ev_t;
    ev_t exp_q[$];

    sstv_line_sequencer #(
        .SYNC_MIN_CYCLES(SMIN), .SYNC_MAX_CYCLES(SMAX), .PORCH_CYCLES(PORCH),
        .PIXEL_CYCLES(PC), .PIXELS_PER_LINE(PPL), .LINES_PER_FRAME(LPF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .freq(freq), .color(color),
        .pixel_valid(pixel_valid), .pixel_color(pixel_color), .pixel_x(pixel_x),
        .line_y(line_y), .line_done(line_done), .frame_done(frame_done),
        .sync_err(sync_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin : mon
        ev_t  e;
        logic hit;
        if (reset_n === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                hit = (k == 0) ? pixel_valid : (k == 1) ? line_done : (k == 2) ? frame_done : sync_err;
                if (hit === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL event: unexpected kind=%0d at edge %0d x=%0d y=%0d col=%0d, none required",
                                 k, edges, pixel_x, line_y, pixel_color);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.at != edges ||
                            (k == 0 && (e.x != int'(pixel_x) || e.y != int'(line_y) || e.col != int'(pixel_color)))) begin
                            errors++;
                            $display("FAIL event: got kind=%0d edge=%0d x=%0d y=%0d col=%0d, required kind=%0d edge=%0d x=%0d y=%0d col=%0d",
                                     k, edges, pixel_x, line_y, pixel_color, e.kind, e.at, e.x, e.y, e.col);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [11:0] sync_f();
        int r = $urandom_range(0, 3);
        return (r == 0) ? 12'd1100 : (r == 1) ? 12'd1300 : 12'($urandom_range(1100, 1300));
    endfunction

    function automatic logic [11:0] off_f();
        int r = $urandom_range(0, 3);
        return (r == 0) ? 12'd1099 : (r == 1) ? 12'd1301 :
               (r == 2) ? 12'($urandom_range(0, 1098)) : 12'($urandom_range(1302, 4095));
    endfunction

    task automatic tick(input logic [11:0] f, input logic [1:0] c);
        freq  = f;
        color = c;
        @(negedge clk);
    endtask

    // Drives one line attempt: gap idle clocks, L sync clocks, then porch and pixels.
    // partial stops right after the x=1 strobe so the caller can interrupt the line.
    task automatic drive_line(input int L, input int gap, input int fixed, input bit partial);
        int t, trans, last, p;
        int cols[PPL];
        logic [11:0] f;
        logic [1:0]  c;
        for (int i = 0; i < gap; i++) tick(off_f(), 2'($urandom));
        t = edges + 1;
        for (int i = 0; i < L; i++) tick(fixed >= 0 ? 12'd1200 : sync_f(), 2'($urandom));
        if (L < SMIN) begin
            tick(fixed >= 0 ? 12'd1500 : off_f(), 2'($urandom));
            return;
        end
        trans = t + L + PORCH;
        for (int i = 0; i < PPL; i++) cols[i] = (fixed >= 0) ? fixed : int'($urandom_range(0, 3));
        for (int i = 0; i < (partial ? 2 : PPL); i++)
            exp_q.push_back('{0, trans + i * PC + PC / 2, i, exp_y, cols[i]});
        if (!partial) begin
            exp_q.push_back('{1, trans + PPL * PC, 0, 0, 0});
            if (exp_y == LPF - 1) exp_q.push_back('{2, trans + PPL * PC, 0, 0, 0});
            exp_y = (exp_y + 1) % LPF;
        end
        last = partial ? trans + PC + PC / 2 : trans + PPL * PC;
        for (int n = t + L; n <= last; n++) begin
            f = (fixed >= 0) ? 12'd2200 : (n == t + L) ? off_f() : 12'($urandom_range(0, 4095));
            c = (fixed >= 0) ? 2'(fixed) : 2'($urandom);
            p = (n - trans - 1) / PC;
            if (n > trans && p < PPL) c = 2'(cols[p]);
            tick(f, c);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        freq    = 12'd0;
        color   = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pixel_valid, pixel_color, pixel_x, line_y, line_done, frame_done, sync_err, busy} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {pixel_valid, pixel_color, pixel_x, line_y, line_done, frame_done, sync_err, busy});
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(off_f(), 2'd0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_basic_line();
        drive_line(6, 1, 3, 1'b0);
        repeat (2) tick(12'd2200, 2'd3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: %0d events not seen, required 0", exp_q.size()); end
        checks++;
        if (int'(line_y) != exp_y || pixel_x !== 8'd2) begin
            errors++;
            $display("FAIL basic_hold: got y=%0d x=%0d, required y=%0d x=2", line_y, pixel_x, exp_y);
        end
    endtask

    task automatic test_glitch();
        for (int L = 1; L < SMIN; L++) begin
            drive_line(L, 1, (L == 3) ? 0 : -1, 1'b0);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy L=%0d: got %b, required 0", L, busy); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_events: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_sync_timeout();
        int t;
        t = edges + 1;
        exp_q.push_back('{3, t + SMAX - 1, 0, 0, 0});
        repeat (25) tick(sync_f(), 2'($urandom));
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stuck_busy: got %b, required 0", busy); end
        tick(off_f(), 2'd0);
        t = edges + 1;
        exp_q.push_back('{3, t + SMAX - 1, 0, 0, 0});
        repeat (SMAX) tick(sync_f(), 2'($urandom));
        tick(off_f(), 2'd0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL exact_max_busy: got %b, required 0", busy); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_events: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_sync_bounds();
        drive_line(SMIN, 1, -1, 1'b0);
        drive_line(SMAX - 1, 2, -1, 1'b0);
        tick(off_f(), 2'd0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bounds_events: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        enable = 1'b0;
        tick(off_f(), 2'd0);
        checks++;
        if (line_y !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disable_clear: got y=%0d busy=%b, required y=0 busy=0", line_y, busy);
        end
        exp_y  = 0;
        enable = 1'b1;
        repeat (3) drive_line($urandom_range(SMIN, SMAX - 1), 0, -1, 1'b0);
        tick(off_f(), 2'd0);
        checks++;
        if (exp_q.size() != 0 || int'(line_y) != exp_y) begin
            errors++;
            $display("FAIL back_to_back: got pending=%0d y=%0d, required pending=0 y=%0d", exp_q.size(), line_y, exp_y);
        end
    endtask

    task automatic test_enable_abort();
        while (exp_y == 0) drive_line($urandom_range(SMIN, SMAX - 1), 1, -1, 1'b0);
        drive_line($urandom_range(SMIN, SMAX - 1), 1, -1, 1'b1);
        enable = 1'b0;
        tick(off_f(), 2'd0);
        exp_y = 0;
        checks++;
        if (busy !== 1'b0 || line_y !== 8'd0) begin
            errors++;
            $display("FAIL enable_abort: got busy=%b y=%0d, required busy=0 y=0", busy, line_y);
        end
        enable = 1'b1;
        repeat (PC) tick(off_f(), 2'd0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_events: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        while (exp_y == 0) drive_line($urandom_range(SMIN, SMAX - 1), 1, -1, 1'b0);
        drive_line($urandom_range(SMIN, SMAX - 1), 1, -1, 1'b1);
        checks++;
        if (pixel_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_strobe: got %b, required 1", pixel_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pixel_valid, pixel_color, pixel_x, line_y, line_done, frame_done, sync_err, busy} !== 24'd0) begin
            errors++;
            $display("FAIL async_reset: got %h, required 0",
                     {pixel_valid, pixel_color, pixel_x, line_y, line_done, frame_done, sync_err, busy});
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_y   = 0;
        drive_line($urandom_range(SMIN, SMAX - 1), 1, -1, 1'b0);
        tick(off_f(), 2'd0);
        checks++;
        if (exp_q.size() != 0 || int'(line_y) != exp_y) begin
            errors++;
            $display("FAIL after_reset: got pending=%0d y=%0d, required pending=0 y=%0d", exp_q.size(), line_y, exp_y);
        end
    endtask

    task automatic test_random_lines();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 4) == 0) drive_line($urandom_range(1, SMIN - 1), $urandom_range(0, 3), -1, 1'b0);
            else drive_line($urandom_range(SMIN, SMAX - 1), $urandom_range(0, 3), -1, 1'b0);
        end
        tick(off_f(), 2'd0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL random_events: %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_glitch();
        test_sync_timeout();
        test_sync_bounds();
        test_back_to_back();
        test_enable_abort();
        test_async_reset();
        test_random_lines();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
